sram1rw_param_ctrl: RTL and testbench
=====================================

# sram1rw_param_ctrl

Parametrised single-port (1RW) SRAM block with a valid/ready request port, per-lane write mask, optional output pipeline stage, and a hardware clear engine that zero-fills the array after reset. It generalises the fixed-size SRAM1RWdepthxwidth macro models to arbitrary depth and width. It sits between cache/tag logic and the storage array, and is used where deterministic contents after reset are required.

## Interface
- DEPTH, 128, number of words; any value ≥ 2, not required to be a power of two.
- WIDTH, 22, bits per word.
- LANE_W, 11, write-mask granularity in bits; WIDTH must be a multiple of LANE_W.
- OUT_REG, 0, 0 = read data one cycle after accept; 1 = extra output register, two cycles.
- Derived: ADDR_W = max(1, clog2(DEPTH)); LANES = WIDTH/LANE_W.

- CE  in  1  clock, rising edge active.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  WIDTH  write data.
- req_wmask  in  LANES  per-lane write enable; bit k covers bits [k*LANE_W +: LANE_W].
- rsp_valid  out  1  read data valid, single-cycle pulse.
- rsp_rdata  out  WIDTH  read data.
- init_done  out  1  clear engine finished; level signal.

## Operation
- Accept: the request is taken on a rising CE edge with req_valid && req_ready. At most one operation per cycle.
- FSM states: CLEAR and RUN.
  - RST forces CLEAR with clr_addr = 0.
  - CLEAR writes all-zero to clr_addr each cycle and increments it.
  - When clr_addr == DEPTH-1 is written, the FSM moves to RUN. CLEAR takes exactly DEPTH cycles.
- req_ready = (state == RUN). Requests offered during CLEAR are not accepted and have no effect.
- init_done = 1 in RUN, 0 otherwise.
- Write: for each lane k with req_wmask[k] = 1, memory[req_addr] lane k ← req_wdata lane k. Other lanes are unchanged. A mask of all 0 is a legal no-op. A write produces no response.
- Read: memory[req_addr] is returned on rsp_rdata with a one-cycle rsp_valid pulse.
- Out-of-range address (req_addr ≥ DEPTH, possible only for non-power-of-two DEPTH):
  - write is accepted and ignored;
  - read is accepted and returns all-zero with a normal rsp_valid.
- rsp_rdata holds its last value while rsp_valid = 0.
- There is no response backpressure; the consumer must take the data when rsp_valid = 1.
- Back-to-back reads, writes, or mixes are allowed every cycle. A read issued the cycle after a write to the same address returns the new data.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, init_done 0, clr_addr 0, output pipeline cleared.
- After RST deasserts at edge T0:
  - the clear writes addresses 0..DEPTH-1 on edges T0+1..T0+DEPTH;
  - req_ready and init_done rise to 1 after edge T0+DEPTH;
  - the first request can be accepted at edge T0+DEPTH+1.
- Read latency from accept edge N: rsp_valid is high in the cycle after edge N+1 when OUT_REG = 0, or after edge N+2 when OUT_REG = 1.
- Throughput: one response per cycle, in request order.
- RST asserted mid-clear: the clear restarts from address 0.
- RST asserted with a read in flight: the response is dropped, rsp_valid stays 0, and rsp_rdata goes to 0.
- RST asserted together with req_valid: the request is ignored.

## Test plan
- Reset/clear, DEPTH=128: deassert RST, then hold req_valid=1 with reads.
  - req_ready must rise exactly 128 cycles later.
  - Reading all 128 addresses must return 0.
- Masked write, WIDTH=22, LANE_W=11:
  - write 0x3FFFFF with mask 2'b11 to address 5;
  - write 0x000000 with mask 2'b01 to address 5;
  - read address 5 → 0x3FF800 with rsp_valid one cycle after accept.
- OUT_REG=1 streaming: write addr i ← i for i = 0..7, then issue 8 back-to-back reads. Expect 8 consecutive rsp_valid pulses starting 2 cycles after the first accept, with data 0..7.
- Write-then-read same address on consecutive cycles (addr 3 ← 0x155555, then read 3) → 0x155555.
- Reset mid-clear: pulse RST at clear cycle 60.
  - req_ready must stay 0 for 128 full cycles afterwards.
  - All addresses must read 0.
- DEPTH=100 out of range:
  - write 0x2AAAAA to addr 110 → no effect;
  - read addr 110 → 0;
  - read addr 99 → 0 (value from the clear).

Source files
------------

// File: rtl/sram1rw_param_ctrl.sv
// Single-port SRAM with valid/ready request port, per-lane write mask, an optional
// output register and a clear engine that zero-fills the array after reset.
module sram1rw_param_ctrl #(
  parameter  int DEPTH   = 128,
  parameter  int WIDTH   = 22,
  parameter  int LANE_W  = 11,
  parameter  int OUT_REG = 0,
  localparam int ADDR_W  = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH),
  localparam int LANES   = WIDTH / LANE_W
) (
  input  logic              CE,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  input  logic [LANES-1:0]  req_wmask,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              init_done
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] w_clr_addr_nxt;

  logic w_clearing;
  logic w_accept;
  logic w_in_range;
  logic w_do_wr;
  logic w_do_rd;

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             r_s1_v;
  logic [WIDTH-1:0] r_s1_d;
  logic             r_s2_v;
  logic [WIDTH-1:0] r_s2_d;

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values;
  // the combinational blocks use = and are evaluated in order.
  always_ff @(posedge CE) begin
    if (RST) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    if (r_state == ST_CLEAR) begin
      if (r_clr_addr == LAST_ADDR) begin
        w_state_nxt    = ST_RUN;
        w_clr_addr_nxt = '0;
      end else begin
        w_clr_addr_nxt = r_clr_addr + ADDR_W'(1);
      end
    end
  end

  assign req_ready  = (r_state == ST_RUN);
  assign init_done  = (r_state == ST_RUN);
  assign w_clearing = (r_state == ST_CLEAR) && !RST;
  assign w_accept   = req_valid && req_ready && !RST;
  assign w_in_range = ({1'b0, req_addr} < DEPTH_EXT);
  assign w_do_wr    = w_accept && req_write && w_in_range;
  assign w_do_rd    = w_accept && !req_write;

  // NOTE: the array itself has no reset branch; the clear engine zero-fills it after
  // RST, and resetting it directly would turn the RAM into plain flops.
  always_ff @(posedge CE) begin
    if (w_clearing) begin
      r_mem[r_clr_addr] <= '0;
    end else if (w_do_wr) begin
      for (int k = 0; k < LANES; k++) begin
        if (req_wmask[k]) begin
          r_mem[req_addr][k*LANE_W +: LANE_W] <= req_wdata[k*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Read pipeline: array read, then the response register; data only moves with valid.
  always_ff @(posedge CE) begin
    if (RST) begin
      r_s1_v <= 1'b0;
      r_s1_d <= '0;
      r_s2_v <= 1'b0;
      r_s2_d <= '0;
    end else begin
      r_s1_v <= w_do_rd;
      if (w_do_rd) begin
        r_s1_d <= w_in_range ? r_mem[req_addr] : '0;
      end
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_d <= r_s1_d;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic             r_s3_v;
    logic [WIDTH-1:0] r_s3_d;

    always_ff @(posedge CE) begin
      if (RST) begin
        r_s3_v <= 1'b0;
        r_s3_d <= '0;
      end else begin
        r_s3_v <= r_s2_v;
        if (r_s2_v) begin
          r_s3_d <= r_s2_d;
        end
      end
    end

    assign rsp_valid = r_s3_v;
    assign rsp_rdata = r_s3_d;
  end else begin : g_no_out_reg
    assign rsp_valid = r_s2_v;
    assign rsp_rdata = r_s2_d;
  end

endmodule

// File: tb/tb_sram1rw_param_ctrl.sv
// Bench for sram1rw_param_ctrl: three instances (128/OUT_REG=0, 128/OUT_REG=1, 100/OUT_REG=0)
// share one stimulus stream and are compared every cycle against an array/queue model.
module tb_sram1rw_param_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [6:0]  req_addr;
  logic [21:0] req_wdata;
  logic [1:0]  req_wmask;

  logic [2:0]  o_ready;
  logic [2:0]  o_valid;
  logic [2:0]  o_done;
  logic [21:0] o_rdata [3];

  always #5 clk = ~clk;

  sram1rw_param_ctrl #(.DEPTH(128), .WIDTH(22), .LANE_W(11), .OUT_REG(0)) u_a (
    .CE(clk), .RST(rst), .req_valid(req_valid), .req_ready(o_ready[0]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(o_valid[0]), .rsp_rdata(o_rdata[0]), .init_done(o_done[0]));

  sram1rw_param_ctrl #(.DEPTH(128), .WIDTH(22), .LANE_W(11), .OUT_REG(1)) u_b (
    .CE(clk), .RST(rst), .req_valid(req_valid), .req_ready(o_ready[1]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(o_valid[1]), .rsp_rdata(o_rdata[1]), .init_done(o_done[1]));

  sram1rw_param_ctrl #(.DEPTH(100), .WIDTH(22), .LANE_W(11), .OUT_REG(0)) u_c (
    .CE(clk), .RST(rst), .req_valid(req_valid), .req_ready(o_ready[2]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(o_valid[2]), .rsp_rdata(o_rdata[2]), .init_done(o_done[2]));

  // Reference model: per-instance array contents, clear progress, and a queue of
  // read responses tagged with the cycle they must appear in.
  typedef struct {
    int          inst;
    int          due;
    logic [21:0] data;
  } rsp_t;

  typedef struct {
    bit          wr;
    logic [6:0]  addr;
    logic [21:0] wdata;
    logic [1:0]  mask;
    logic [21:0] exp;
  } vec_t;

  int          m_depth [3];
  int          m_lat   [3];
  int          clr     [3];
  logic [21:0] last_rd [3];
  logic [21:0] mm      [3][128];
  rsp_t        rq[$];
  int          cyc;
  bit          model_on;
  int          n_vec;
  int          n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit v, input bit w, input logic [6:0] a,
                       input logic [21:0] d, input logic [1:0] m);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 7'd0, 22'd0, 2'b00);
  endtask

  // Advance the model for the coming edge, clock the DUTs, then compare on the falling edge.
  task automatic step();
    logic [21:0] rd;
    cyc++;
    if (rst) begin
      model_on = 1'b1;
      rq.delete();
      for (int i = 0; i < 3; i++) begin
        clr[i]     = 0;
        last_rd[i] = '0;
        for (int a = 0; a < 128; a++) mm[i][a] = '0;
      end
    end else if (model_on) begin
      for (int i = 0; i < 3; i++) begin
        if (clr[i] < m_depth[i]) begin
          clr[i]++;
        end else if (req_valid) begin
          if (req_write) begin
            if (int'(req_addr) < m_depth[i]) begin
              for (int k = 0; k < 2; k++)
                if (req_wmask[k]) mm[i][req_addr][k*11 +: 11] = req_wdata[k*11 +: 11];
            end
          end else begin
            rd = (int'(req_addr) < m_depth[i]) ? mm[i][req_addr] : 22'd0;
            rq.push_back('{i, cyc + m_lat[i], rd});
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (model_on) begin
      for (int i = 0; i < 3; i++) begin
        bit ev;
        ev = 1'b0;
        foreach (rq[j]) begin
          if (rq[j].inst == i && rq[j].due == cyc) begin
            ev         = 1'b1;
            last_rd[i] = rq[j].data;
          end
        end
        check($sformatf("req_ready[%0d]", i), o_ready[i], clr[i] == m_depth[i]);
        check($sformatf("init_done[%0d]", i), o_done[i], clr[i] == m_depth[i]);
        check($sformatf("rsp_valid[%0d]", i), o_valid[i], ev);
        check($sformatf("rsp_rdata[%0d]", i), o_rdata[i], last_rd[i]);
      end
      for (int j = rq.size() - 1; j >= 0; j--) begin
        if (rq[j].due <= cyc) rq.delete(j);
      end
    end
  endtask

  initial begin
    vec_t tbl [8];
    int   n;
    int   cl_c;

    m_depth = '{128, 128, 100};
    m_lat   = '{1, 2, 1};
    n_vec   = 0;
    n_err   = 0;
    cyc     = 0;
    model_on = 1'b0;

    tbl[0] = '{1'b1, 7'd5, 22'h3FFFFF, 2'b11, 22'h0};
    tbl[1] = '{1'b1, 7'd5, 22'h000000, 2'b01, 22'h0};
    tbl[2] = '{1'b0, 7'd5, 22'h000000, 2'b00, 22'h3FF800};
    tbl[3] = '{1'b1, 7'd5, 22'h000000, 2'b00, 22'h0};
    tbl[4] = '{1'b0, 7'd5, 22'h000000, 2'b00, 22'h3FF800};
    tbl[5] = '{1'b1, 7'd7, 22'h2AAAAA, 2'b10, 22'h0};
    tbl[6] = '{1'b0, 7'd7, 22'h000000, 2'b00, 22'h2AA800};
    tbl[7] = '{1'b0, 7'd9, 22'h000000, 2'b00, 22'h000000};

    // Reset state
    rst = 1'b1;
    idle();
    step();
    step();

    // Clear length with reads held on the port
    rst = 1'b0;
    drive(1'b1, 1'b0, 7'd0, 22'd0, 2'b00);
    n    = 0;
    cl_c = 0;
    while (o_ready[0] !== 1'b1 && n < 300) begin
      step();
      n++;
      if (o_ready[2] === 1'b1 && cl_c == 0) cl_c = n;
    end
    check("clear_len_128", n, 128);
    check("clear_len_100", cl_c, 100);
    for (int a = 0; a < 128; a++) begin
      drive(1'b1, 1'b0, 7'(a), 22'd0, 2'b00);
      step();
    end
    idle();
    repeat (3) step();

    // Table-driven masked writes and reads
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, tbl[j].wr, tbl[j].addr, tbl[j].wdata, tbl[j].mask);
      step();
      idle();
      if (!tbl[j].wr) begin
        step();
        check($sformatf("tbl%0d_valid_a", j), o_valid[0], 1);
        check($sformatf("tbl%0d_data_a", j), o_rdata[0], tbl[j].exp);
        check($sformatf("tbl%0d_data_c", j), o_rdata[2], tbl[j].exp);
        step();
        check($sformatf("tbl%0d_valid_b", j), o_valid[1], 1);
        check($sformatf("tbl%0d_data_b", j), o_rdata[1], tbl[j].exp);
      end
    end

    // Write followed immediately by a read of the same address
    drive(1'b1, 1'b1, 7'd3, 22'h155555, 2'b11);
    step();
    drive(1'b1, 1'b0, 7'd3, 22'd0, 2'b00);
    step();
    idle();
    step();
    check("wr_then_rd_valid", o_valid[0], 1);
    check("wr_then_rd_data", o_rdata[0], 22'h155555);
    step();

    // OUT_REG=1 streaming
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 7'(i), 22'(i), 2'b11);
      step();
    end
    for (int i = 0; i < 11; i++) begin
      if (i < 8) drive(1'b1, 1'b0, 7'(i), 22'd0, 2'b00);
      else idle();
      step();
      if (i >= 2 && i <= 9) begin
        check($sformatf("stream%0d_valid", i - 2), o_valid[1], 1);
        check($sformatf("stream%0d_data", i - 2), o_rdata[1], 32'(i - 2));
      end else begin
        check($sformatf("stream_gap%0d", i), o_valid[1], 0);
      end
    end

    // Out-of-range on the DEPTH=100 instance
    drive(1'b1, 1'b1, 7'd110, 22'h2AAAAA, 2'b11);
    step();
    drive(1'b1, 1'b0, 7'd110, 22'd0, 2'b00);
    step();
    idle();
    step();
    check("oor_rd_valid", o_valid[2], 1);
    check("oor_rd_data", o_rdata[2], 0);
    check("inrange_110_data", o_rdata[0], 22'h2AAAAA);
    drive(1'b1, 1'b0, 7'd99, 22'd0, 2'b00);
    step();
    idle();
    step();
    check("rd99_valid", o_valid[2], 1);
    check("rd99_data", o_rdata[2], 0);
    step();

    // Reset with a read in flight, then reset again mid-clear
    drive(1'b1, 1'b0, 7'd5, 22'd0, 2'b00);
    step();
    rst = 1'b1;
    idle();
    step();
    check("rst_drop_valid_a", o_valid[0], 0);
    check("rst_drop_data_a", o_rdata[0], 0);
    check("rst_drop_valid_b", o_valid[1], 0);
    rst = 1'b0;
    repeat (60) step();
    rst = 1'b1;
    drive(1'b1, 1'b1, 7'd1, 22'h3FFFFF, 2'b11);
    step();
    rst = 1'b0;
    drive(1'b1, 1'b0, 7'd0, 22'd0, 2'b00);
    for (int k = 1; k <= 128; k++) begin
      step();
      if (k == 127 || k == 128) check($sformatf("midclr_ready_%0d", k), o_ready[0], k == 128);
    end
    for (int a = 0; a < 128; a++) begin
      drive(1'b1, 1'b0, 7'(a), 22'd0, 2'b00);
      step();
    end

    // Randomised traffic with occasional resets
    for (int t = 0; t < 3000; t++) begin
      rst = ($urandom_range(0, 399) == 0);
      drive(1'($urandom), 1'($urandom), 7'($urandom_range(0, 127)), 22'($urandom), 2'($urandom));
      step();
    end
    rst = 1'b0;
    idle();
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
